wb_gpio_bank: RTL

Parametrised Wishbone GPIO controller that replaces hard-wired pin assignments on board-level SoC tops with a software-visible bank of up to 32 bidirectional pins. It sits on the peripheral Wishbone bus in the `wb_clk` domain next to the UART. It provides per-pin direction, atomic set/clear, input synchronisation and per-pin edge-triggered interrupts. The board top drives the tri-state pads from `gpio_o` and `gpio_oe`.

---
 rtl/wb_gpio_bank.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: per-pin direction, atomic set/clear, synchronised inputs.
// Define GPIO_IRQ_EN to build the per-pin edge interrupt block (offsets 0x14-0x20, irq_o).
module wb_gpio_bank #(
   parameter int GPIO_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  wb_clk,
   input  logic                  wb_rst,
   input  logic [3:0]            wb_adr_i,
   input  logic [31:0]           wb_dat_i,
   output logic [31:0]           wb_dat_o,
   input  logic [3:0]            wb_sel_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   output logic                  wb_ack_o,
   input  logic [GPIO_WIDTH-1:0] gpio_i,
   output logic [GPIO_WIDTH-1:0] gpio_o,
   output logic [GPIO_WIDTH-1:0] gpio_oe,
   output logic                  irq_o
);

   logic                                  r_ack;
   logic [31:0]                           r_dat;
   logic [GPIO_WIDTH-1:0]                 r_dout;
   logic [GPIO_WIDTH-1:0]                 r_dir;
   logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync;

   logic                  w_acc;
   logic                  w_wr;
   logic [31:0]           w_lane;
   logic [GPIO_WIDTH-1:0] w_mask;
   logic [GPIO_WIDTH-1:0] w_wdat;
   logic [GPIO_WIDTH-1:0] w_din;
   logic [31:0]           w_rdat;
   logic                  w_unused_bits;

   // One wait state: an access is taken only while ack is low, so acks alternate.
   assign w_acc  = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_wr   = w_acc & wb_we_i;
   assign w_lane = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
   assign w_mask = w_lane[GPIO_WIDTH-1:0];
   assign w_wdat = wb_dat_i[GPIO_WIDTH-1:0] & w_mask;
   assign w_din  = r_sync[SYNC_STAGES-1];
   assign w_unused_bits = ^{wb_dat_i, w_lane};

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_i};
      end
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_dout <= '0;
         r_dir  <= '0;
      end else if (w_wr) begin
         case (wb_adr_i)
            4'h1:    r_dout <= (r_dout & ~w_mask) | w_wdat;
            4'h2:    r_dout <= r_dout | w_wdat;
            4'h3:    r_dout <= r_dout & ~w_wdat;
            4'h4:    r_dir  <= (r_dir & ~w_mask) | w_wdat;
            default: ;
         endcase
      end
   end

`ifdef GPIO_IRQ_EN
   logic [GPIO_WIDTH-1:0] r_prev;
   logic [GPIO_WIDTH-1:0] r_en;
   logic [GPIO_WIDTH-1:0] r_rise;
   logic [GPIO_WIDTH-1:0] r_fall;
   logic [GPIO_WIDTH-1:0] r_stat;
   logic [GPIO_WIDTH-1:0] w_edge;
   logic [GPIO_WIDTH-1:0] w_w1c;

   assign w_edge = (w_din & ~r_prev & r_rise) | (~w_din & r_prev & r_fall);
   assign w_w1c  = (w_wr && (wb_adr_i == 4'h8)) ? w_wdat : '0;

   // A new edge outranks a same-cycle W1C of that bit.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_prev <= '0;
         r_en   <= '0;
         r_rise <= '0;
         r_fall <= '0;
         r_stat <= '0;
      end else begin
         r_prev <= w_din;
         r_stat <= (r_stat & ~w_w1c) | w_edge;
         if (w_wr) begin
            case (wb_adr_i)
               4'h5:    r_en   <= (r_en   & ~w_mask) | w_wdat;
               4'h6:    r_rise <= (r_rise & ~w_mask) | w_wdat;
               4'h7:    r_fall <= (r_fall & ~w_mask) | w_wdat;
               default: ;
            endcase
         end
      end
   end

   assign irq_o = |(r_stat & r_en);
`else
   assign irq_o = 1'b0;
`endif

   always_comb begin
      w_rdat = '0;
      case (wb_adr_i)
         4'h0:    w_rdat[GPIO_WIDTH-1:0] = w_din;
         4'h1:    w_rdat[GPIO_WIDTH-1:0] = r_dout;
         4'h4:    w_rdat[GPIO_WIDTH-1:0] = r_dir;
`ifdef GPIO_IRQ_EN
         4'h5:    w_rdat[GPIO_WIDTH-1:0] = r_en;
         4'h6:    w_rdat[GPIO_WIDTH-1:0] = r_rise;
         4'h7:    w_rdat[GPIO_WIDTH-1:0] = r_fall;
         4'h8:    w_rdat[GPIO_WIDTH-1:0] = r_stat;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         r_ack <= 1'b0;
         r_dat <= '0;
      end else begin
         r_ack <= w_acc;
         if (w_acc) begin
            r_dat <= w_rdat;
         end
      end
   end

   assign wb_ack_o = r_ack;
   assign wb_dat_o = r_dat;
   assign gpio_o   = r_dout;
   assign gpio_oe  = r_dir;

endmodule
